// File: rtl/pmem_arb_pkg.sv
// Shared definitions for the program-memory arbiter: state encoding and default widths.
package pmem_arb_pkg;

  localparam int unsigned DEF_PC_WIDTH   = 12;
  localparam int unsigned DEF_PMEM_WIDTH = 16;
  localparam int unsigned DEF_MAX_BURST  = 4;

  localparam logic [1:0] FE  = 2'd0;
  localparam logic [1:0] LD  = 2'd1;
  localparam logic [1:0] GAP = 2'd2;

  typedef enum logic [1:0] {
    StFe  = FE,
    StLd  = LD,
    StGap = GAP
  } arb_state_e;

  // Burst counter width; never zero so MAX_BURST=1 still gets a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Fetch, loader and program-memory signals of the arbiter, bundled with arbiter/environment views.
interface pmem_arbiter_if #(
  parameter int unsigned PC_WIDTH   = pmem_arb_pkg::DEF_PC_WIDTH,
  parameter int unsigned PMEM_WIDTH = pmem_arb_pkg::DEF_PMEM_WIDTH
) ();

  logic [PC_WIDTH-1:0]   in_fe_addr;
  logic [PMEM_WIDTH-1:0] out_fe_instr;
  logic                  out_fe_stall;

  logic                  in_ld_req;
  logic                  in_ld_we;
  logic [PC_WIDTH-1:0]   in_ld_addr;
  logic [PMEM_WIDTH-1:0] in_ld_wdata;
  logic                  out_ld_ack;
  logic                  out_ld_rvalid;
  logic [PMEM_WIDTH-1:0] out_ld_rdata;

  logic                  in_halt;

  logic [PC_WIDTH-1:0]   out_pmem_addr;
  logic                  out_pmem_we;
  logic [PMEM_WIDTH-1:0] out_pmem_wdata;
  logic [PMEM_WIDTH-1:0] in_pmem_rdata;

  // Arbiter side.
  modport slave (
    input  in_fe_addr, in_ld_req, in_ld_we, in_ld_addr, in_ld_wdata, in_halt, in_pmem_rdata,
    output out_fe_instr, out_fe_stall, out_ld_ack, out_ld_rvalid, out_ld_rdata,
    output out_pmem_addr, out_pmem_we, out_pmem_wdata
  );

  // Fetch stage, loader and memory side.
  modport master (
    output in_fe_addr, in_ld_req, in_ld_we, in_ld_addr, in_ld_wdata, in_halt, in_pmem_rdata,
    input  out_fe_instr, out_fe_stall, out_ld_ack, out_ld_rvalid, out_ld_rdata,
    input  out_pmem_addr, out_pmem_we, out_pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Shares the single program-memory port between instruction fetch and a loader/debug master.
// Define PMEM_ARB_HALT_EN to let in_halt lift the loader burst limit.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH,
  parameter int unsigned PMEM_WIDTH = DEF_PMEM_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic           clock,
  input  logic           reset,
  pmem_arbiter_if.slave  bus
);

  localparam int unsigned CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e            state;
  logic [CW-1:0]         cnt;
  logic                  src_ff;
  logic                  rd_ff;
  logic [PMEM_WIDTH-1:0] held;

  logic ld_grant;
  logic halt_eff;

`ifdef PMEM_ARB_HALT_EN
  assign halt_eff = bus.in_halt;
`else
  logic unused_halt;
  assign unused_halt = bus.in_halt;
  assign halt_eff    = 1'b0;
`endif

  // The loader only owns the port in LD while it is actually requesting.
  assign ld_grant = (state == StLd) && bus.in_ld_req;

  assign bus.out_pmem_addr  = ld_grant ? bus.in_ld_addr  : bus.in_fe_addr;
  assign bus.out_pmem_we    = ld_grant && bus.in_ld_we;
  assign bus.out_pmem_wdata = ld_grant ? bus.in_ld_wdata : '0;

  assign bus.out_ld_ack     = ld_grant;
  assign bus.out_fe_stall   = (state != StFe);

  assign bus.out_ld_rvalid  = src_ff && rd_ff;
  assign bus.out_ld_rdata   = bus.in_pmem_rdata;

  // After a loader cycle the memory returns loader data, so fetch sees the last word it got.
  assign bus.out_fe_instr   = src_ff ? held : bus.in_pmem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= StFe;
      cnt    <= '0;
      src_ff <= 1'b0;
      rd_ff  <= 1'b0;
      held   <= '0;
    end else begin
      src_ff <= ld_grant;
      rd_ff  <= ld_grant && !bus.in_ld_we;
      if (!src_ff) begin
        held <= bus.in_pmem_rdata;
      end

      unique case (state)
        StFe: begin
          if (bus.in_ld_req) begin
            state <= StLd;
            cnt   <= '0;
          end
        end
        StLd: begin
          if (bus.in_ld_req) begin
            if ((cnt == CNT_LAST) && !halt_eff) begin
              state <= StGap;
              cnt   <= '0;
            end else if (cnt != CNT_LAST) begin
              // Saturates while halted so a later halt release ends the burst on the next ack.
              cnt <= cnt + CW'(1);
            end
          end else begin
            state <= StGap;
            cnt   <= '0;
          end
        end
        StGap: begin
          state <= StFe;
        end
        default: begin
          state <= StFe;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: per-cycle ownership/data model plus literal spot checks.
module tb_pmem_arbiter;

  localparam int unsigned PCW = 12;
  localparam int unsigned DW  = 16;
  localparam int unsigned MB  = 4;

`ifdef PMEM_ARB_HALT_EN
  localparam bit HALT_EN      = 1'b1;
  localparam int RUN_HALT     = 10;
  localparam int RUN_RELEASE  = 7;
`else
  localparam bit HALT_EN      = 1'b0;
  localparam int RUN_HALT     = 4;
  localparam int RUN_RELEASE  = 4;
`endif

  logic clock;
  logic reset;

  pmem_arbiter_if #(.PC_WIDTH(PCW), .PMEM_WIDTH(DW)) bus ();

  pmem_arbiter #(
    .PC_WIDTH  (PCW),
    .PMEM_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h020) ? 16'hBEEF : (lo ^ 16'hA5A5);
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read program memory.
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] rdata_q;
  assign bus.in_pmem_rdata = rdata_q;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
    rdata_q = '0;
    forever begin
      @(posedge clock);
      rdata_q <= ram[bus.out_pmem_addr];
      if (bus.out_pmem_we) ram[bus.out_pmem_addr] <= bus.out_pmem_wdata;
    end
  end

  // Model: who owns the port this cycle, whether a gap is owed, and what memory holds.
  logic [DW-1:0]  mmem [4096];
  bit             own, gap, prev_ld, prev_rd, primed, grant;
  int             burst;
  logic [DW-1:0]  held_m, exp_rd, e_instr;
  logic [PCW-1:0] e_addr;
  bit             e_ack, e_stall, e_we, e_rvalid;

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = init_word(i);
    own = 0; gap = 0; prev_ld = 0; prev_rd = 0; primed = 0; burst = 0;
    held_m = '0; exp_rd = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        grant = 0; e_ack = 0; e_stall = 0; e_we = 0; e_rvalid = 0;
        e_addr = bus.in_fe_addr; e_instr = exp_rd;
      end else begin
        grant    = own && bus.in_ld_req;
        e_ack    = grant;
        e_stall  = own || gap;
        e_addr   = grant ? bus.in_ld_addr : bus.in_fe_addr;
        e_we     = grant && bus.in_ld_we;
        e_rvalid = prev_ld && prev_rd;
        e_instr  = prev_ld ? held_m : exp_rd;
      end
      if (primed) begin
        chk("m_ack",    bus.out_ld_ack,    e_ack);
        chk("m_stall",  bus.out_fe_stall,  e_stall);
        chk("m_addr",   bus.out_pmem_addr, e_addr);
        chk("m_we",     bus.out_pmem_we,   e_we);
        chk("m_rvalid", bus.out_ld_rvalid, e_rvalid);
        chk("m_instr",  bus.out_fe_instr,  e_instr);
        if (e_rvalid) chk("m_rdata", bus.out_ld_rdata, exp_rd);
        if (e_we) chk("m_wdata", bus.out_pmem_wdata, bus.in_ld_wdata);
      end
      if (reset) begin
        own = 0; gap = 0; burst = 0; prev_ld = 0; prev_rd = 0; held_m = '0;
        exp_rd = mmem[e_addr];
      end else begin
        if (!prev_ld) held_m = exp_rd;
        prev_ld = grant;
        prev_rd = grant && !bus.in_ld_we;
        exp_rd  = mmem[e_addr];
        if (e_we) mmem[e_addr] = bus.in_ld_wdata;
        if (gap) begin
          gap = 0;
        end else if (own) begin
          if (grant) begin
            burst++;
            if (burst >= MB && !(HALT_EN && bus.in_halt)) begin
              own = 0; gap = 1;
            end
          end else begin
            own = 0; gap = 1;
          end
        end else if (bus.in_ld_req) begin
          own = 1; burst = 0;
        end
      end
      primed = 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.out_ld_ack && n < 8) begin
      step();
      @(negedge clock);
      n++;
    end
    chk(name, bus.out_ld_ack, 1'b1);
  endtask

  initial begin
    bit exp_ack [8];
    bit exp_stall [8];
    int acks, run, best;
    exp_ack   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    bus.in_fe_addr  = 12'h055;
    bus.in_ld_req   = 1'b0;
    bus.in_ld_we    = 1'b0;
    bus.in_ld_addr  = '0;
    bus.in_ld_wdata = '0;
    bus.in_halt     = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_stall",  bus.out_fe_stall,  1'b0);
    chk("rst_ack",    bus.out_ld_ack,    1'b0);
    chk("rst_rvalid", bus.out_ld_rvalid, 1'b0);
    chk("rst_we",     bus.out_pmem_we,   1'b0);
    chk("rst_addr",   bus.out_pmem_addr, 12'h055);
    step();
    reset = 1'b0;

    // Fetch alone owns the port.
    for (int i = 0; i < 10; i++) begin
      bus.in_fe_addr = 12'h100 + 12'(i);
      @(negedge clock);
      chk("idle_stall", bus.out_fe_stall,  1'b0);
      chk("idle_ack",   bus.out_ld_ack,    1'b0);
      chk("idle_addr",  bus.out_pmem_addr, 12'h100 + 12'(i));
      step();
    end

    // Held write request: FE, 4 acks, GAP, FE, LD again.
    bus.in_fe_addr  = 12'h180;
    bus.in_ld_req   = 1'b1;
    bus.in_ld_we    = 1'b1;
    bus.in_ld_addr  = 12'h010;
    bus.in_ld_wdata = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("burst_ack",   bus.out_ld_ack,   exp_ack[k]);
      chk("burst_stall", bus.out_fe_stall, exp_stall[k]);
      step();
    end
    bus.in_ld_req = 1'b0;
    bus.in_ld_we  = 1'b0;
    repeat (3) step();
    chk("wr_mem", ram[12'h010], 16'h1234);

    // Loader read: data one cycle after the ack, fetch sees its held word.
    bus.in_fe_addr = 12'h100;
    bus.in_ld_req  = 1'b1;
    bus.in_ld_addr = 12'h020;
    wait_ack("rd_ack");
    step();
    bus.in_ld_req = 1'b0;
    @(negedge clock);
    chk("rd_rvalid", bus.out_ld_rvalid, 1'b1);
    chk("rd_rdata",  bus.out_ld_rdata,  16'hBEEF);
    chk("rd_held",   bus.out_fe_instr,  16'hA4A5);
    step();
    repeat (3) step();

    // Halted core: burst limit lifted only when the halt exemption is built in.
    bus.in_halt     = 1'b1;
    bus.in_ld_req   = 1'b1;
    bus.in_ld_we    = 1'b1;
    bus.in_ld_addr  = 12'h200;
    bus.in_ld_wdata = 16'h5A00;
    acks = 0; run = 0; best = 0;
    for (int k = 0; k < 30 && acks < 10; k++) begin
      @(negedge clock);
      if (bus.out_ld_ack) begin
        acks++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      step();
      bus.in_ld_wdata = 16'h5A00 + 16'(acks);
    end
    bus.in_ld_req = 1'b0;
    bus.in_ld_we  = 1'b0;
    bus.in_halt   = 1'b0;
    chk("halt_acks", acks, 10);
    chk("halt_run",  best, RUN_HALT);
    repeat (3) step();

    // Halt released past the limit: burst ends on the next ack.
    bus.in_halt    = 1'b1;
    bus.in_ld_req  = 1'b1;
    bus.in_ld_addr = 12'h300;
    run = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.out_ld_ack) run++;
      else if (run > 0) break;
      step();
      if (run == 6) bus.in_halt = 1'b0;
    end
    step();
    bus.in_ld_req = 1'b0;
    bus.in_halt   = 1'b0;
    chk("release_run", run, RUN_RELEASE);
    repeat (3) step();

    // Reset on the second ack of a read burst.
    bus.in_ld_req  = 1'b1;
    bus.in_ld_addr = 12'h030;
    wait_ack("abort_ack1");
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("abort_stall",  bus.out_fe_stall,  1'b0);
    chk("abort_ack",    bus.out_ld_ack,    1'b0);
    chk("abort_rvalid", bus.out_ld_rvalid, 1'b0);
    step();
    reset = 1'b0;
    bus.in_ld_req = 1'b0;
    @(negedge clock);
    chk("post_rvalid", bus.out_ld_rvalid, 1'b0);
    chk("post_stall",  bus.out_fe_stall,  1'b0);
    chk("post_ack",    bus.out_ld_ack,    1'b0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter PC_WIDTH, 12, address width of program memory and PC.
REQ-002 Parameter PMEM_WIDTH, 16, program memory data width.
REQ-003 Parameter MAX_BURST, 4, max consecutive loader accesses before fetch regains the port (>=1).
REQ-004 clock  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_fe_addr  input  PC_WIDTH  fetch-stage next-PC address.
REQ-007 out_fe_instr  output  PMEM_WIDTH  instruction word returned to fetch stage.
REQ-008 out_fe_stall  output  1  drives fetch-stage stall; PC must hold while high.
REQ-009 in_ld_req  input  1  loader/debug access request, held until acked.
REQ-010 in_ld_we  input  1  1 = write, 0 = read; qualified by in_ld_req.
REQ-011 in_ld_addr  input  PC_WIDTH  loader access address.
REQ-012 in_ld_wdata  input  PMEM_WIDTH  loader write data.
REQ-013 out_ld_ack  output  1  one-cycle pulse: loader access issued this cycle.
REQ-014 out_ld_rvalid  output  1  loader read data valid on out_ld_rdata.
REQ-015 out_ld_rdata  output  PMEM_WIDTH  loader read data.
REQ-016 in_halt  input  1  core halted; loader burst limit lifted.
REQ-017 out_pmem_addr / out_pmem_we / out_pmem_wdata  output  PC_WIDTH/1/PMEM_WIDTH  program memory port.
REQ-018 in_pmem_rdata  input  PMEM_WIDTH  memory read data, one cycle after address (synchronous read).

Function
REQ-019 FSM states FE, LD, GAP; registered state, burst counter cnt (clog2(MAX_BURST) bits), src_ff (previous cycle issued loader access), rd_ff (that access was a read), held instruction register.
REQ-020 FE: port = in_fe_addr, we=0, stall=0; in_ld_req=1 -> LD next cycle, no ack in FE.
REQ-021 LD with in_ld_req=1: port = in_ld_addr/in_ld_we/in_ld_wdata, out_ld_ack=1, cnt++, stall=1.
REQ-022 LD with in_ld_req=0: port = in_fe_addr, we=0, no ack, stall=1, -> GAP.
REQ-023 LD ack with cnt==MAX_BURST-1 and in_halt=0 -> GAP, cnt cleared; otherwise stay LD.
REQ-024 GAP: port = in_fe_addr, we=0, stall=1, loader request ignored, -> FE unconditionally; guarantees >=1 FE cycle between bursts.
REQ-025 cnt clears on every entry to LD.
REQ-026 out_ld_rvalid = src_ff & rd_ff; out_ld_rdata = in_pmem_rdata (cycle after ack).
REQ-027 out_fe_instr = in_pmem_rdata when src_ff=0, else held register; held register loads in_pmem_rdata on every cycle with src_ff=0.
REQ-028 out_pmem_we never asserted outside an acked loader write.
REQ-029 in_halt deasserting mid-burst with cnt>=MAX_BURST-1 -> GAP after the next ack.

Reset
REQ-030 Reset forces state FE, cnt 0, src_ff 0, rd_ff 0, held 0; outputs: stall 0, ack 0, rvalid 0, we 0, out_pmem_addr = in_fe_addr.
REQ-031 Reset mid-burst aborts it; no ack/rvalid after reset release until a new LD entry.

Configuration
REQ-032 Macro PMEM_ARB_HALT_EN: defined -> REQ-023 halt exemption active; undefined -> in_halt ignored, burst always limited to MAX_BURST.

Structure
REQ-033 Shared package pmem_arb_pkg: state encoding localparams (FE=0, LD=1, GAP=2) and default widths.
REQ-034 Single module; no sub-module.

Verification
REQ-035 Reset, no loader request for 10 cycles -> out_pmem_addr tracks in_fe_addr, stall 0, ack 0.
REQ-036 in_ld_req held, write 0x1234 @0x010, MAX_BURST=4 -> 1 FE cycle, 4 acks, GAP, FE, then LD again; mem[0x010]=0x1234.
REQ-037 Loader read @0x020 (mem=0xBEEF) -> ack cycle t, rvalid=1 and rdata=0xBEEF at t+1, out_fe_instr = held value at t+1.
REQ-038 in_halt=1 with PMEM_ARB_HALT_EN, 10 requests -> 10 consecutive acks, no GAP until req drops.
REQ-039 Reset asserted on 2nd ack of a burst -> state FE, stall 0, no rvalid next cycle.
